// File: rtl/wb_slave_pkg.sv
// Shared constants, status-word layout and address-decode type for the
// Wishbone memory/console responder.
package wb_slave_pkg;

  localparam logic [31:0] DEF_MEM_BASE     = 32'h0000_0000;
  localparam logic [31:0] DEF_CONSOLE_ADDR = 32'h1000_0000;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    DEC_RAM     = 2'd0,
    DEC_CONSOLE = 2'd1,
    DEC_NONE    = 2'd2
  } dec_e;

  function automatic logic [31:0] status_word(input logic [7:0] count,
                                              input logic       full,
                                              input logic       empty);
    logic [31:0] w;
    w                            = '0;
    w[STAT_COUNT_LSB +: 8]       = count;
    w[STAT_FULL]                 = full;
    w[STAT_EMPTY]                = empty;
    return w;
  endfunction

endpackage

// File: rtl/wb_slave_mem_console_fifo.sv
// Show-ahead console FIFO. When empty, the output holds the last byte popped
// (zero after reset) so the byte stream never shows stale storage contents.
module wb_console_fifo #(
  parameter int P_WIDTH      = 8,
  parameter int P_DEPTH_LOG2 = 3
) (
  input  logic                    i_clk,
  input  logic                    i_reset_sync,
  input  logic                    i_push,
  input  logic [P_WIDTH-1:0]      i_data,
  input  logic                    i_pop,
  output logic [P_WIDTH-1:0]      o_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [P_DEPTH_LOG2:0]   o_count
);

  localparam int                     LP_DEPTH   = 2 ** P_DEPTH_LOG2;
  localparam logic [P_DEPTH_LOG2:0]  LP_FULL    = {1'b1, {P_DEPTH_LOG2{1'b0}}};
  localparam logic [P_DEPTH_LOG2:0]  LP_CNT_ONE = 1;
  localparam logic [P_DEPTH_LOG2-1:0] LP_PTR_ONE = 1;

  logic [P_WIDTH-1:0]      r_mem [LP_DEPTH];
  logic [P_DEPTH_LOG2-1:0] r_wr_ptr;
  logic [P_DEPTH_LOG2-1:0] r_rd_ptr;
  logic [P_DEPTH_LOG2:0]   r_count;
  logic [P_WIDTH-1:0]      r_hold;
  logic                    w_push;
  logic                    w_pop;

  assign o_full  = (r_count == LP_FULL);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = o_empty ? r_hold : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset_sync) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_hold   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
        r_hold   <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_CNT_ONE;
        2'b01:   r_count <= r_count - LP_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_slave_mem_console.sv
// Wishbone pipeline responder: byte-lane RAM on both channels plus a console
// byte register whose writes are queued and streamed out on valid/ready.
module wb_slave_mem_console
  import wb_slave_pkg::*;
#(
  parameter int          P_MEM_ADDR_BITS   = 18,
  parameter logic [31:0] P_MEM_BASE        = DEF_MEM_BASE,
  parameter logic [31:0] P_CONSOLE_ADDR    = DEF_CONSOLE_ADDR,
  parameter int          P_FIFO_DEPTH_LOG2 = 3,
  parameter              P_INIT_FILE       = ""
) (
  input  logic        i_clk,
  input  logic        i_reset_sync,
  input  logic        i_slave_read_stb,
  output logic        o_slave_read_ack,
  input  logic [31:0] i_slave_read_addr,
  output logic [31:0] o_slave_read_data,
  input  logic        i_slave_write_stb,
  output logic        o_slave_write_ack,
  input  logic [31:0] i_slave_write_addr,
  input  logic [31:0] i_slave_write_data,
  input  logic [3:0]  i_slave_write_sel,
  output logic        o_console_valid,
  input  logic        i_console_ready,
  output logic [7:0]  o_console_data,
  output logic        o_bus_error
);

  localparam int LP_IDX_W = P_MEM_ADDR_BITS - 2;
  localparam int LP_WORDS = 2 ** LP_IDX_W;

  function automatic dec_e decode(input logic [31:0] addr);
    if (addr == P_CONSOLE_ADDR) begin
      return DEC_CONSOLE;
    end else if (addr[31:P_MEM_ADDR_BITS] == P_MEM_BASE[31:P_MEM_ADDR_BITS]) begin
      return DEC_RAM;
    end
    return DEC_NONE;
  endfunction

  logic [3:0][7:0]           r_mem [LP_WORDS];
  logic [31:0]               r_ram_q;
  logic [31:0]               r_rd_status;
  dec_e                      r_rd_dec;
  logic                      r_read_ack;
  logic                      r_write_ack;
  logic                      r_bus_error;

  dec_e                      w_rd_dec;
  dec_e                      w_wr_dec;
  logic                      w_rd_accept;
  logic                      w_wr_accept;
  logic                      w_ram_we;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic [P_FIFO_DEPTH_LOG2:0] w_fifo_count;
  logic [LP_IDX_W-1:0]       w_rd_idx;
  logic [LP_IDX_W-1:0]       w_wr_idx;

  assign w_rd_dec = decode(i_slave_read_addr);
  assign w_wr_dec = decode(i_slave_write_addr);
  assign w_rd_idx = i_slave_read_addr[P_MEM_ADDR_BITS-1:2];
  assign w_wr_idx = i_slave_write_addr[P_MEM_ADDR_BITS-1:2];

  // Reset blocks acceptance so an in-flight write never reaches the RAM.
  assign w_rd_accept = i_slave_read_stb & ~r_read_ack & ~i_reset_sync;
  assign w_wr_accept = i_slave_write_stb & ~r_write_ack & ~i_reset_sync
                     & ~((w_wr_dec == DEC_CONSOLE) & w_fifo_full);
  assign w_ram_we    = w_wr_accept & (w_wr_dec == DEC_RAM);
  assign w_push      = w_wr_accept & (w_wr_dec == DEC_CONSOLE) & i_slave_write_sel[0];
  assign w_pop       = o_console_valid & i_console_ready;

  // Single process for read and write gives read-before-write on a shared word.
  always_ff @(posedge i_clk) begin
    for (int lane = 0; lane < 4; lane++) begin
      if (w_ram_we && i_slave_write_sel[lane]) begin
        r_mem[w_wr_idx][lane] <= i_slave_write_data[8*lane +: 8];
      end
    end
    if (w_rd_accept) begin
      r_ram_q <= r_mem[w_rd_idx];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset_sync) begin
      r_read_ack  <= 1'b0;
      r_write_ack <= 1'b0;
      r_bus_error <= 1'b0;
      r_rd_dec    <= DEC_NONE;
      r_rd_status <= '0;
    end else begin
      r_read_ack  <= w_rd_accept;
      r_write_ack <= w_wr_accept;
      r_bus_error <= (w_rd_accept & (w_rd_dec == DEC_NONE))
                   | (w_wr_accept & (w_wr_dec == DEC_NONE));
      if (w_rd_accept) begin
        r_rd_dec    <= w_rd_dec;
        r_rd_status <= status_word(8'(w_fifo_count), w_fifo_full, w_fifo_empty);
      end
    end
  end

  always_comb begin
    o_slave_read_data = '0;
    if (r_read_ack) begin
      case (r_rd_dec)
        DEC_RAM:     o_slave_read_data = r_ram_q;
        DEC_CONSOLE: o_slave_read_data = r_rd_status;
        default:     o_slave_read_data = '0;
      endcase
    end
  end

  assign o_slave_read_ack  = r_read_ack;
  assign o_slave_write_ack = r_write_ack;
  assign o_bus_error       = r_bus_error;
  assign o_console_valid   = ~w_fifo_empty;

  wb_console_fifo #(
    .P_WIDTH      (8),
    .P_DEPTH_LOG2 (P_FIFO_DEPTH_LOG2)
  ) u_fifo (
    .i_clk        (i_clk),
    .i_reset_sync (i_reset_sync),
    .i_push       (w_push),
    .i_data       (i_slave_write_data[7:0]),
    .i_pop        (w_pop),
    .o_data       (o_console_data),
    .o_full       (w_fifo_full),
    .o_empty      (w_fifo_empty),
    .o_count      (w_fifo_count)
  );

endmodule

// File: tb/tb_wb_slave_mem_console.sv
// Directed bench: tasks drive transactions and queue expectations, a negedge
// monitor pops and compares whenever the DUT acks or emits a console byte.
module tb_wb_slave_mem_console;

  localparam logic [31:0] CON = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        rstb, rd_ack, wstb, wr_ack, bus_err, c_valid, c_ready;
  logic [31:0] raddr, rdata, waddr, wdata;
  logic [3:0]  wsel;
  logic [7:0]  c_data;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rd_exp_t;

  rd_exp_t     rq[$];
  logic        wq[$];
  logic [7:0]  cq[$];

  always #5 clk = ~clk;

  wb_slave_mem_console dut (
    .i_clk              (clk),
    .i_reset_sync       (rst),
    .i_slave_read_stb   (rstb),
    .o_slave_read_ack   (rd_ack),
    .i_slave_read_addr  (raddr),
    .o_slave_read_data  (rdata),
    .i_slave_write_stb  (wstb),
    .o_slave_write_ack  (wr_ack),
    .i_slave_write_addr (waddr),
    .i_slave_write_data (wdata),
    .i_slave_write_sel  (wsel),
    .o_console_valid    (c_valid),
    .i_console_ready    (c_ready),
    .o_console_data     (c_data),
    .o_bus_error        (bus_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares outputs half a cycle away from the active edge.
  rd_exp_t m_re;
  logic    m_err;
  always @(negedge clk) begin
    m_err = 1'b0;
    if (rd_ack) begin
      if (rq.size() == 0) begin
        chk("rd_unexpected_ack", 32'd1, 32'd0);
      end else begin
        m_re = rq.pop_front();
        chk("rd_data", rdata, m_re.data);
        m_err = m_err | m_re.err;
      end
    end else if (!rst) begin
      chk("rd_data_zero_idle", rdata, 32'd0);
    end
    if (wr_ack) begin
      if (wq.size() == 0) chk("wr_unexpected_ack", 32'd1, 32'd0);
      else m_err = m_err | wq.pop_front();
    end
    if (rd_ack || wr_ack) chk("bus_error", 32'(bus_err), 32'(m_err));
    if (c_valid && c_ready) begin
      if (cq.size() == 0) chk("con_unexpected_byte", 32'(c_data), 32'hFFFF_FFFF);
      else chk("con_byte", 32'(c_data), 32'(cq.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic err);
    int lat;
    step();
    wstb = 1'b1; waddr = a; wdata = d; wsel = s;
    wq.push_back(err);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!wr_ack && lat < 20);
    wstb = 1'b0;
    chk("wr_latency", 32'(lat), 32'd1);
    $display("[TB] write %h <= %h sel %b (latency %0d)", a, d, s, lat);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input logic err);
    step();
    rstb = 1'b1; raddr = a;
    rq.push_back('{exp, err});
    step();
    rstb = 1'b0;
    chk("rd_latency_ack", 32'(rd_ack), 32'd1);
    $display("[TB] read  %h expect %h err %b", a, exp, err);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rstb = 1'b0; wstb = 1'b0; c_ready = 1'b0;
    raddr = '0; waddr = '0; wdata = '0; wsel = '0;
    repeat (3) step();
    chk("reset_rd_ack",  32'(rd_ack),  32'd0);
    chk("reset_wr_ack",  32'(wr_ack),  32'd0);
    chk("reset_rdata",   rdata,        32'd0);
    chk("reset_bus_err", 32'(bus_err), 32'd0);
    chk("reset_valid",   32'(c_valid), 32'd0);
    chk("reset_cdata",   32'(c_data),  32'd0);
    rst = 1'b0;

    // RAM full-word write then byte-lane merge with misaligned read address.
    wr(32'h100, 32'hDEAD_BEEF, 4'hF, 1'b0);
    rd(32'h100, 32'hDEAD_BEEF, 1'b0);
    wr(32'h100, 32'h0000_00AA, 4'b0001, 1'b0);
    rd(32'h102, 32'hDEAD_BEAA, 1'b0);

    // Console with sink ready: bytes stream in order, FIFO ends empty.
    c_ready = 1'b1;
    cq.push_back(8'h48);
    wr(CON, 32'h48, 4'b0001, 1'b0);
    cq.push_back(8'h69);
    wr(CON, 32'h69, 4'b0001, 1'b0);
    repeat (4) step();
    rd(CON, 32'h0000_0001, 1'b0);
    c_ready = 1'b0;

    // Fill the FIFO, then a ninth write must stall until one byte is popped.
    for (int i = 1; i <= 8; i++) begin
      cq.push_back(8'(i));
      wr(CON, 32'(i), 4'b0001, 1'b0);
    end
    step();
    wstb = 1'b1; waddr = CON; wdata = 32'h09; wsel = 4'b0001;
    wq.push_back(1'b0);
    rstb = 1'b1; raddr = CON;
    rq.push_back('{32'h0000_0802, 1'b0});
    step();
    rstb = 1'b0;
    chk("wr9_stall_a", 32'(wr_ack), 32'd0);
    step();
    step();
    chk("wr9_stall_b", 32'(wr_ack), 32'd0);
    c_ready = 1'b1;
    step();
    c_ready = 1'b0;
    chk("wr9_stall_at_pop", 32'(wr_ack), 32'd0);
    step();
    chk("wr9_ack_after_pop", 32'(wr_ack), 32'd1);
    wstb = 1'b0;
    cq.push_back(8'h09);
    $display("[TB] write %h <= 09 after full stall", CON);
    c_ready = 1'b1;
    repeat (12) step();
    c_ready = 1'b0;
    rd(CON, 32'h0000_0001, 1'b0);

    // Same-cycle read and write to one word: read sees the old contents.
    wr(32'h200, 32'h1111_1111, 4'hF, 1'b0);
    step();
    rstb = 1'b1; raddr = 32'h200;
    wstb = 1'b1; waddr = 32'h200; wdata = 32'h2222_2222; wsel = 4'hF;
    rq.push_back('{32'h1111_1111, 1'b0});
    wq.push_back(1'b0);
    step();
    chk("rw_same_rd_ack", 32'(rd_ack), 32'd1);
    chk("rw_same_wr_ack", 32'(wr_ack), 32'd1);
    rstb = 1'b0; wstb = 1'b0;
    $display("[TB] simultaneous read/write at 00000200");
    rd(32'h200, 32'h2222_2222, 1'b0);

    // Unmapped accesses and a console write with sel[0]=0 (no push).
    rd(32'h2000_0000, 32'h0, 1'b1);
    wr(32'h2000_0004, 32'h5, 4'hF, 1'b1);
    wr(CON, 32'h77, 4'b1110, 1'b0);
    step();
    chk("con_no_push_sel0", 32'(c_valid), 32'd0);

    // Reset while a write is pending: no ack, RAM keeps its contents.
    step();
    wstb = 1'b1; waddr = 32'h100; wdata = 32'h0; wsel = 4'hF;
    rst = 1'b1;
    step();
    chk("rst_drops_wr_ack", 32'(wr_ack), 32'd0);
    rst = 1'b0; wstb = 1'b0;
    step();
    chk("rst_wr_ack_idle", 32'(wr_ack), 32'd0);
    rd(32'h100, 32'hDEAD_BEAA, 1'b0);

    repeat (3) step();
    chk("rd_queue_drained",  32'(rq.size()), 32'd0);
    chk("wr_queue_drained",  32'(wq.size()), 32'd0);
    chk("con_queue_drained", 32'(cq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
